gate_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 2-input logic gates (nor_gate and siblings). On a start request it drives the gate's a/b inputs through all four input vectors, waits a settle window, samples y, and compares it against a golden function. It records per-vector failures and an error count, then reports pass/fail. It sits between a test/config master and a single gate instance, replacing hand-written stimulus with a reusable on-chip checker.

---
 rtl/gate_test_pkg.sv | 28 ++
 rtl/gate_golden.sv | 24 ++
 rtl/gate_bist_ctrl.sv | 140 ++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and helpers for 2-input gate self-test: golden function codes,
// BIST sequencer states and the vector count.
package gate_test_pkg;

  localparam int unsigned NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    FUNC_NOR  = 3'd0,
    FUNC_NAND = 3'd1,
    FUNC_AND  = 3'd2,
    FUNC_OR   = 3'd3,
    FUNC_XOR  = 3'd4,
    FUNC_XNOR = 3'd5
  } gate_func_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  // Codes 6 and 7 are reserved.
  function automatic logic is_valid_func(input logic [2:0] f);
    return f <= 3'(FUNC_XNOR);
  endfunction

endpackage

// File: rtl/gate_golden.sv
// Golden reference for a 2-input gate selected by a function code.
module gate_golden
  import gate_test_pkg::*;
(
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  always_comb begin
    y_exp = 1'b0;
    case (func)
      FUNC_NOR:  y_exp = ~(a | b);
      FUNC_NAND: y_exp = ~(a & b);
      FUNC_AND:  y_exp = a & b;
      FUNC_OR:   y_exp = a | b;
      FUNC_XOR:  y_exp = a ^ b;
      FUNC_XNOR: y_exp = ~(a ^ b);
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps a 2-input gate through all input vectors, checks y
// against a golden function after a settle window, and reports pass/fail.
module gate_bist_ctrl
  import gate_test_pkg::*;
#(
  parameter  int unsigned SETTLE_CYCLES = 2,
  parameter  int unsigned NUM_PASSES    = 1,
  localparam int unsigned ERR_W         = $clog2(4 * NUM_PASSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       func,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec,
  output logic             cfg_err
);

  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  bist_state_e       state;
  logic [2:0]        func_q;
  logic [CNT_W-1:0]  cnt;
  logic [PASS_W-1:0] pass_idx;
  logic [1:0]        vec;
  logic              y_exp;
  logic              mismatch;
  logic              last_vec;
  logic [ERR_W-1:0]  err_upd;

  gate_golden u_golden (
    .func  (func_q),
    .a     (a),
    .b     (b),
    .y_exp (y_exp)
  );

  assign vec      = {a, b};
  assign mismatch = (y != y_exp);
  assign last_vec = (vec == 2'(NUM_VECTORS - 1)) &&
                    (pass_idx == PASS_W'(NUM_PASSES - 1));

  // Saturating error count including the current check result.
  always_comb begin
    err_upd = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) err_upd = err_cnt + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      func_q   <= '0;
      cnt      <= '0;
      pass_idx <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            if (is_valid_func(func)) begin
              func_q   <= func;
              err_cnt  <= '0;
              fail_vec <= '0;
              pass     <= 1'b0;
              cnt      <= CNT_W'(SETTLE_CYCLES);
              pass_idx <= '0;
              busy     <= 1'b1;
              state    <= ST_SETTLE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (abort) begin
            state <= ST_IDLE;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (cnt == CNT_W'(1)) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Abort wins over the check: partial results stay as they were.
          if (abort) begin
            state <= ST_IDLE;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            if (mismatch) fail_vec[vec] <= 1'b1;
            err_cnt <= err_upd;
            if (last_vec) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (err_upd == '0);
              busy  <= 1'b0;
              a     <= 1'b0;
              b     <= 1'b0;
            end else begin
              {a, b} <= vec + 2'd1;
              if (vec == 2'(NUM_VECTORS - 1)) pass_idx <= pass_idx + PASS_W'(1);
              cnt   <= CNT_W'(SETTLE_CYCLES);
              state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: default-parameter instance plus a
// two-pass / one-settle-cycle instance, each driving a modelled gate.
module tb_gate_bist_ctrl;
  import gate_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start0, start1, abort, y0, y1;
  logic [2:0] func;
  logic [1:0] mode;  // 0: real NOR gate, 1: stuck-at-0, 2: stuck-at-1

  logic       a0, b0, busy0, done0, pass0, cfg0;
  logic [2:0] err0;
  logic [3:0] fv0;
  logic       a1, b1, busy1, done1, pass1, cfg1;
  logic [3:0] err1;
  logic [3:0] fv1;

  always #5 clk = ~clk;

  function automatic logic gate_model(input logic [1:0] m, input logic ga, input logic gb);
    case (m)
      2'd0:    return ~(ga | gb);
      2'd1:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign y0 = gate_model(mode, a0, b0);
  assign y1 = gate_model(mode, a1, b1);

  gate_bist_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .func(func), .y(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fv0), .cfg_err(cfg0)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(1), .NUM_PASSES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .func(func), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1), .cfg_err(cfg1)
  );

  // Observation mux selecting the instance under test.
  int unsigned sel;
  logic        o_a, o_b, o_busy, o_done, o_pass, o_cfg;
  logic [31:0] o_err, o_fv;

  always_comb begin
    if (sel == 0) begin
      o_a = a0; o_b = b0; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_cfg = cfg0; o_err = 32'(err0); o_fv = 32'(fv0);
    end else begin
      o_a = a1; o_b = b1; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_cfg = cfg1; o_err = 32'(err1); o_fv = 32'(fv1);
    end
  end

  typedef struct {
    int lat;
    int err;
    int fv;
    int pass;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: push expectation, pulse start, follow cycle by cycle until done.
  task automatic run(input int which, input logic [2:0] f, input logic [1:0] m,
                     input exp_t e, input int abort_at, input int restart_at);
    int   s, p, c;
    bit   seen;
    exp_t r;
    s = (which != 0) ? 1 : 2;
    p = (which != 0) ? 2 : 1;
    sel  = which;
    mode = m;
    func = f;
    sb.push_back(e);
    if (which != 0) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    c    = 1;
    seen = 1'b0;
    while (c <= e.lat + 5) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      check_eq("busy", 32'(o_busy), 32'(c <= 4 * (s + 1) * p));
      check_eq("vec", 32'({o_a, o_b}), 32'(((c - 1) / (s + 1)) % 4));
      if (c == abort_at) abort = 1'b1;
      if (c == restart_at) begin
        func = 3'(FUNC_NAND);
        if (which != 0) start1 = 1'b1; else start0 = 1'b1;
      end
      tick();
      abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
      c++;
      if (abort_at != 0 && c == abort_at + 1) begin
        r = sb.pop_front();
        check_eq("abort_busy", 32'(o_busy), 32'd0);
        check_eq("abort_vec", 32'({o_a, o_b}), 32'd0);
        check_eq("abort_pass", 32'(o_pass), 32'(r.pass));
        check_eq("abort_err", o_err, 32'(r.err));
        check_eq("abort_fv", o_fv, 32'(r.fv));
        repeat (20) begin
          tick();
          check_eq("abort_nodone", 32'(o_done), 32'd0);
          check_eq("abort_idle", 32'(o_busy), 32'd0);
        end
        func = 3'(FUNC_NOR);
        return;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    r = sb.pop_front();
    if (seen) begin
      check_eq("latency", 32'(c), 32'(r.lat));
      check_eq("err_cnt", o_err, 32'(r.err));
      check_eq("fail_vec", o_fv, 32'(r.fv));
      check_eq("pass", 32'(o_pass), 32'(r.pass));
      check_eq("done_vec", 32'({o_a, o_b}), 32'd0);
      check_eq("done_busy", 32'(o_busy), 32'd0);
      tick();
      check_eq("done_pulse", 32'(o_done), 32'd0);
      check_eq("hold_pass", 32'(o_pass), 32'(r.pass));
      check_eq("hold_err", o_err, 32'(r.err));
    end
    func = 3'(FUNC_NOR);
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    abort  = 1'b0;
    func   = 3'(FUNC_NOR);
    mode   = 2'd0;
    sel    = 0;

    // Reset dominates a held start on both instances.
    repeat (2) begin
      tick();
      check_eq("rst_busy0", 32'(busy0), 32'd0);
      check_eq("rst_busy1", 32'(busy1), 32'd0);
      check_eq("rst_outs0", 32'({a0, b0, done0, pass0, cfg0}), 32'd0);
      check_eq("rst_res0", 32'({err0, fv0}), 32'd0);
      check_eq("rst_outs1", 32'({a1, b1, done1, pass1, cfg1, err1, fv1}), 32'd0);
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    tick();
    check_eq("idle_busy", 32'(busy0 | busy1), 32'd0);

    run(0, 3'(FUNC_NOR),  2'd0, '{lat: 13, err: 0, fv: 4'b0000, pass: 1}, 0, 0);
    run(0, 3'(FUNC_NOR),  2'd1, '{lat: 13, err: 1, fv: 4'b0001, pass: 0}, 0, 0);
    run(0, 3'(FUNC_NAND), 2'd0, '{lat: 13, err: 2, fv: 4'b0110, pass: 0}, 0, 0);

    // Reserved codes: cfg_err pulse, no run, results untouched.
    sel = 0;
    for (int code = 6; code < 8; code++) begin
      func   = 3'(code);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check_eq("cfg_pulse", 32'(cfg0), 32'd1);
      check_eq("cfg_busy", 32'(busy0), 32'd0);
      tick();
      check_eq("cfg_clear", 32'(cfg0), 32'd0);
      check_eq("cfg_busy2", 32'(busy0), 32'd0);
      check_eq("cfg_fv", 32'(fv0), 32'd6);
      check_eq("cfg_err_cnt", 32'(err0), 32'd2);
    end
    func = 3'(FUNC_NOR);

    run(1, 3'(FUNC_NOR), 2'd2, '{lat: 17, err: 6, fv: 4'b1110, pass: 0}, 0, 0);
    run(0, 3'(FUNC_NOR), 2'd0, '{lat: 13, err: 0, fv: 4'b0000, pass: 1}, 0, 4);
    run(0, 3'(FUNC_NOR), 2'd1, '{lat: 13, err: 1, fv: 4'b0001, pass: 0}, 5, 0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
